// File: rtl/ifetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: core constants, FSM states
// and the layout of a fetched-instruction queue entry.
package ifetch_stage_pkg;

   localparam int          XLEN       = 32;
   localparam int          ILEN_BYTES = 4;
   localparam logic [31:0] INSN_NOP   = 32'h0000_0013;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_e;

   // 65-bit entry handed to decode: {fault, pc, instr}
   typedef struct packed {
      logic            fault;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   function automatic fetch_entry_t make_entry(input logic            fault,
                                               input logic [XLEN-1:0] pc,
                                               input logic [XLEN-1:0] instr);
      fetch_entry_t e;
      e.fault = fault;
      e.pc    = pc;
      e.instr = instr;
      return e;
   endfunction

endpackage

// File: rtl/ifetch_stage_fetch_queue.sv
// Two-entry FIFO between fetch and decode; slot0 is always the head.
// A push and a pop may happen in the same cycle even when full; flush empties it.
module fetch_queue
   import ifetch_stage_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         enq,
   input  fetch_entry_t enq_data,
   input  logic         deq,
   output fetch_entry_t head_data,
   output logic [1:0]   count
);

   fetch_entry_t slot0;
   fetch_entry_t slot1;
   logic         do_deq;
   logic         do_enq;

   assign do_deq    = deq && (count != 2'd0);
   assign do_enq    = enq && ((count != 2'd2) || do_deq);
   assign head_data = slot0;

   // Entries shift toward slot0 on a pop, so the head never needs a read pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot0 <= '0;
         slot1 <= '0;
         count <= 2'd0;
      end else if (flush) begin
         count <= 2'd0;
      end else begin
         case ({do_enq, do_deq})
            2'b11: begin
               if (count == 2'd1) begin
                  slot0 <= enq_data;
               end else begin
                  slot0 <= slot1;
                  slot1 <= enq_data;
               end
            end
            2'b10: begin
               if (count == 2'd0) begin
                  slot0 <= enq_data;
               end else begin
                  slot1 <= enq_data;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               slot0 <= slot1;
               count <= count - 2'd1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: owns the PC, reads a combinational imem and queues
// {pc, instr, fault} for decode; redirects flush the queue and retarget the PC.
module ifetch_stage
   import ifetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_BYTES = 131072,
   parameter int unsigned QDEPTH     = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic        out_fault
);

   localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - ILEN_BYTES);
   localparam logic [1:0]  QCAP    = 2'(QDEPTH);

   fetch_state_e state;
   fetch_state_e next_state;
   logic [31:0]  pc;
   logic [31:0]  next_pc;
   logic [1:0]   count;
   fetch_entry_t head;
   fetch_entry_t enq_data;
   logic         enq;
   logic         deq;
   logic         space;
   logic         pc_fault;

   assign imem_addr = pc;
   assign out_valid = (count != 2'd0);
   assign out_pc    = head.pc;
   assign out_instr = head.instr;
   assign out_fault = head.fault;

   assign deq      = out_valid && out_ready;
   assign space    = (count < QCAP) || deq;
   assign pc_fault = (pc[1:0] != 2'b00) || (pc > LAST_PC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         pc    <= RESET_PC;
      end else begin
         state <= next_state;
         pc    <= next_pc;
      end
   end

   // Redirect beats everything; a faulting PC is reported once as a NOP and then parks in HALT
   always_comb begin
      next_state = state;
      next_pc    = pc;
      enq        = 1'b0;
      enq_data   = make_entry(1'b0, pc, imem_data);
      if (redirect_valid) begin
         next_state = RUN;
         next_pc    = redirect_pc;
      end else if ((state == RUN) && space) begin
         enq = 1'b1;
         if (pc_fault) begin
            enq_data   = make_entry(1'b1, pc, INSN_NOP);
            next_state = HALT;
         end else begin
            next_pc = pc + 32'(ILEN_BYTES);
         end
      end
   end

   fetch_queue u_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_valid),
      .enq       (enq),
      .enq_data  (enq_data),
      .deq       (deq),
      .head_data (head),
      .count     (count)
   );

endmodule

// File: tb/tb_ifetch_stage.sv
// Self-checking bench for ifetch_stage: a queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_ifetch_stage;
   import ifetch_stage_pkg::*;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] LAST_PC  = 32'h0001_FFFC;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_fault;

   logic [31:0] mem_salt = 32'h0;

   int checks = 0;
   int errors = 0;

   fetch_entry_t model_q[$];
   logic [31:0]  model_pc;
   bit           model_halted;

   ifetch_stage #(
      .RESET_PC   (RESET_PC),
      .IMEM_BYTES (131072),
      .QDEPTH     (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .out_fault      (out_fault)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return (32'h1000_0000 + addr) ^ mem_salt;
   endfunction

   assign imem_data = mem_word(imem_addr);

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkModel();
      checkOutput("imem_addr", imem_addr, model_pc);
      checkOutput("out_valid", {31'b0, out_valid}, {31'b0, model_q.size() != 0});
      if (model_q.size() != 0) begin
         checkOutput("out_pc", out_pc, model_q[0].pc);
         checkOutput("out_instr", out_instr, model_q[0].instr);
         checkOutput("out_fault", {31'b0, out_fault}, {31'b0, model_q[0].fault});
      end
   endtask

   task automatic resetModel();
      model_q.delete();
      model_pc     = RESET_PC;
      model_halted = 1'b0;
   endtask

   // One clock edge of the fetch rules, applied to the model
   task automatic modelStep(input logic rv, input logic [31:0] rpc, input logic rdy);
      bit take;
      take = (model_q.size() != 0) && rdy;
      if (rv) begin
         model_q.delete();
         model_pc     = rpc;
         model_halted = 1'b0;
      end else begin
         if (take) void'(model_q.pop_front());
         if (!model_halted && model_q.size() < 2) begin
            if ((model_pc % 4) != 0 || model_pc > LAST_PC) begin
               model_q.push_back(make_entry(1'b1, model_pc, INSN_NOP));
               model_halted = 1'b1;
            end else begin
               model_q.push_back(make_entry(1'b0, model_pc, mem_word(model_pc)));
               model_pc = model_pc + 32'd4;
            end
         end
      end
   endtask

   // Entered and left at a falling edge: drive, compare, advance the model
   task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic rdy);
      redirect_valid = rv;
      redirect_pc    = rpc;
      out_ready      = rdy;
      #1;
      checkModel();
      modelStep(rv, rpc, rdy);
      @(negedge clk);
   endtask

   task automatic doReset();
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      out_ready      = 1'b0;
      #1;
      resetModel();
      checkOutput("rst_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("rst_pc", out_pc, 32'd0);
      checkOutput("rst_instr", out_instr, 32'd0);
      checkOutput("rst_fault", {31'b0, out_fault}, 32'd0);
      checkOutput("rst_addr", imem_addr, RESET_PC);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] tgt;
      logic        rv;
      logic        rdy;

      @(negedge clk);
      doReset();

      // Straight-line fetch from reset
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("first_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("first_pc", out_pc, 32'h0);
      checkOutput("first_instr", out_instr, 32'h1000_0000);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("second_pc", out_pc, 32'h4);
      checkOutput("second_instr", out_instr, 32'h1000_0004);
      repeat (4) applyStimulus(1'b0, 32'h0, 1'b1);

      // Backpressure fills the queue and freezes the fetch address
      doReset();
      repeat (7) applyStimulus(1'b0, 32'h0, 1'b0);
      checkOutput("stall_addr", imem_addr, 32'h8);
      checkOutput("stall_head", out_pc, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("resume_pc4", out_pc, 32'h4);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("resume_pc8", out_pc, 32'h8);

      // Redirect while full and dequeuing
      applyStimulus(1'b1, 32'h40, 1'b1);
      checkOutput("flush_valid", {31'b0, out_valid}, 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("redir_pc40", out_pc, 32'h40);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("redir_pc44", out_pc, 32'h44);

      // Misaligned target faults once then halts
      applyStimulus(1'b1, 32'h42, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("mis_pc", out_pc, 32'h42);
      checkOutput("mis_instr", out_instr, 32'h0000_0013);
      checkOutput("mis_fault", {31'b0, out_fault}, 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("halt_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("halt_addr", imem_addr, 32'h42);
      applyStimulus(1'b1, 32'h80, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("unhalt_pc", out_pc, 32'h80);

      // Running off the end of imem
      applyStimulus(1'b1, 32'h0001_FFF8, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("last_pc", out_pc, 32'h0001_FFFC);
      checkOutput("last_fault", {31'b0, out_fault}, 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("oob_pc", out_pc, 32'h0002_0000);
      checkOutput("oob_fault", {31'b0, out_fault}, 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("oob_halt", {31'b0, out_valid}, 32'd0);

      // Reset in the middle of a full queue
      applyStimulus(1'b1, 32'h100, 1'b1);
      repeat (3) applyStimulus(1'b0, 32'h0, 1'b0);
      #2;
      doReset();
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("post_rst_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("post_rst_pc", out_pc, RESET_PC);

      // Randomized traffic against the model
      mem_salt = $urandom;
      for (int i = 0; i < 3000; i++) begin
         rdy = ($urandom_range(0, 9) < 7);
         rv  = ($urandom_range(0, 19) == 0);
         case ($urandom_range(0, 3))
            0:       tgt = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            1:       tgt = 32'h0001_FFE0 + 32'($urandom_range(0, 35));
            2:       tgt = $urandom;
            default: tgt = 32'($urandom_range(0, 1023));
         endcase
         if ($urandom_range(0, 499) == 0) begin
            doReset();
         end else begin
            applyStimulus(rv, tgt, rdy);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
